multi_cycle_control: RTL and testbench
======================================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 The block SHALL have ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
REQ-002 opcode, input, 6, instruction opcode from IR; sampled only in DECODE.
REQ-003 zero, input, 1, ALU zero flag; sampled only in BRANCH.
REQ-004 pc_write, output, 1, PC load enable; includes resolved branch condition.
REQ-005 iord, output, 1, memory address select: 0 = PC, 1 = ALUOut.
REQ-006 mem_read / mem_write / ir_write / reg_write, output, 1 each, datapath enables.
REQ-007 reg_dst, output, 2, write register select: 00 = rt, 01 = rd, 10 = r31.
REQ-008 mem_to_reg, output, 2, write data select: 00 = ALUOut, 01 = MDR, 10 = PC.
REQ-009 alu_src_a, output, 1: 0 = PC, 1 = reg A.
REQ-010 alu_src_b, output, 2: 00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
REQ-011 alu_op, output, 2: 00 = add, 01 = sub, 10 = use funct, 11 = slt.
REQ-012 pc_src, output, 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-013 state, output, 4, current state encoding, for debug.

Function
REQ-014 The block SHALL use opcodes: R=000000, J=010000, JAL=011000, BEQ=100000, BNE=101000, ADDI=000001, SLTI=010001, LW=011100, SW=011101.
REQ-015 The state encoding SHALL be: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, JAL=10, I_EXEC=11, I_WB=12.
REQ-016 All outputs SHALL be 0 except those listed for the current state; outputs SHALL be Moore, except pc_write in BRANCH.
REQ-017 FETCH SHALL assert mem_read=1, iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, pc_write=1, then go to DECODE.
REQ-018 DECODE SHALL assert alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut) and dispatch:
- LW/SW -> MEM_ADDR
- R -> R_EXEC
- BEQ/BNE -> BRANCH
- J -> JUMP
- JAL -> JAL
- ADDI/SLTI -> I_EXEC
- any other opcode -> FETCH (treated as a NOP)
REQ-019 MEM_ADDR SHALL assert alu_src_a=1, alu_src_b=10, alu_op=00; it goes to MEM_RD if the opcode latched at DECODE is LW, else MEM_WR.
REQ-020 MEM_RD SHALL assert mem_read=1, iord=1; -> MEM_WB.
REQ-021 MEM_WB SHALL assert reg_write=1, reg_dst=00, mem_to_reg=01; -> FETCH.
REQ-022 MEM_WR SHALL assert mem_write=1, iord=1; -> FETCH.
REQ-023 R_EXEC SHALL assert alu_src_a=1, alu_src_b=00, alu_op=10; -> R_WB.
REQ-024 R_WB SHALL assert reg_write=1, reg_dst=01, mem_to_reg=00; -> FETCH.
REQ-025 I_EXEC SHALL assert alu_src_a=1, alu_src_b=10, alu_op=00 for ADDI and 11 for SLTI; -> I_WB.
REQ-026 I_WB SHALL assert reg_write=1, reg_dst=00, mem_to_reg=00; -> FETCH.
REQ-027 BRANCH SHALL assert alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, and pc_write = zero for BEQ or ~zero for BNE; -> FETCH.
REQ-028 JUMP SHALL assert pc_src=10, pc_write=1; -> FETCH.
REQ-029 JAL SHALL assert pc_src=10, pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10 (PC already holds PC+4); -> FETCH.
REQ-030 The block SHALL latch opcode into an internal register in DECODE; states after DECODE SHALL use the latched value, so opcode changes after DECODE are ignored.
REQ-031 Instruction latency in cycles, counted from FETCH, SHALL be: LW 5; SW, R, ADDI, SLTI 4; BEQ, BNE, J, JAL 3; undefined opcode 2.

Reset
REQ-032 While rst=1 at a clock edge, state SHALL become FETCH and the latched opcode SHALL become 000000.
REQ-033 While rst=1, all outputs except state SHALL be forced to 0.
REQ-034 An rst asserted in any state, mid-instruction included, SHALL abort the instruction with no further reg_write, mem_write or pc_write.
REQ-035 The first cycle after rst deasserts SHALL be FETCH with the FETCH outputs active.

Verification
REQ-036 Reset, then opcode=011100: states SHALL be 0,1,2,3,4,0; mem_read=1 in FETCH and MEM_RD; reg_write=1 with mem_to_reg=01 only in MEM_WB.
REQ-037 BEQ with zero=1 in BRANCH: pc_write=1 and pc_src=01; repeat with zero=0: pc_write=0. BNE: the inverse of both cases.
REQ-038 JAL: state sequence 0,1,10,0; in state 10, reg_dst=10, mem_to_reg=10, pc_write=1, reg_write=1.
REQ-039 opcode=111111: state sequence 0,1,0; reg_write, mem_write and pc_write SHALL stay 0 outside FETCH.
REQ-040 SW with rst=1 asserted during MEM_ADDR: mem_write SHALL never be asserted; the next cycle is state 0 with all outputs 0 except state; FETCH resumes after deassert.
REQ-041 R-type with opcode changed to 011101 during R_EXEC: R_WB SHALL still follow, with reg_dst=01 and reg_write=1.

Source files
------------

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style control unit: a Moore FSM that sequences the shared
// datapath, plus one Mealy term (branch pc_write resolved from the ALU zero flag).
module multi_cycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_JAL      = 4'd10,
    S_I_EXEC   = 4'd11,
    S_I_WB     = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b010000;
  localparam logic [5:0] OP_JAL  = 6'b011000;
  localparam logic [5:0] OP_BEQ  = 6'b100000;
  localparam logic [5:0] OP_BNE  = 6'b101000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_SLTI = 6'b010001;
  localparam logic [5:0] OP_LW   = 6'b011100;
  localparam logic [5:0] OP_SW   = 6'b011101;

  state_t     state_q, state_d;
  logic [5:0] op_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= 6'b000000;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
    end
  end

  assign state = state_q;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = S_FETCH;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'b00;
    mem_to_reg = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;

    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        // Dispatch on the live opcode; later states use the latched copy.
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_R:             state_d = S_R_EXEC;
          OP_BEQ, OP_BNE:   state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_JAL:           state_d = S_JAL;
          OP_ADDI, OP_SLTI: state_d = S_I_EXEC;
          default:          state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_write  = (op_q == OP_BNE) ? ~zero : zero;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      S_JAL: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (op_q == OP_SLTI) ? 2'b11 : 2'b00;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset silences every datapath control immediately, mid-instruction too.
    if (rst) begin
      pc_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 2'b00;
      mem_to_reg = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_src     = 2'b00;
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized scoreboard bench for multi_cycle_control: the driver queues the
// expected per-cycle state/control word, a negedge monitor pops and compares.
module tb_multi_cycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write;
  logic [1:0] reg_dst, mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  multi_cycle_control dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .pc_write   (pc_write),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Control word layout: {pc_write, iord, mem_read, mem_write, ir_write,
  // reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src}
  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctl;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  localparam logic [5:0] R = 6'b000000, J = 6'b010000, JAL = 6'b011000,
                         BEQ = 6'b100000, BNE = 6'b101000, ADDI = 6'b000001,
                         SLTI = 6'b010001, LW = 6'b011100, SW = 6'b011101;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // States visited by one instruction, from FETCH onwards.
  function automatic void seq_for(input logic [5:0] op, output int s[$]);
    s = '{0, 1};
    case (op)
      LW:         s = '{0, 1, 2, 3, 4};
      SW:         s = '{0, 1, 2, 5};
      R:          s = '{0, 1, 6, 7};
      ADDI, SLTI: s = '{0, 1, 11, 12};
      BEQ, BNE:   s = '{0, 1, 8};
      J:          s = '{0, 1, 9};
      JAL:        s = '{0, 1, 10};
      default:    s = '{0, 1};
    endcase
  endfunction

  function automatic logic [16:0] pack(input bit pcw, input bit io, input bit mr,
      input bit mw, input bit irw, input bit rw, input logic [1:0] rd,
      input logic [1:0] m2r, input bit sa, input logic [1:0] sb,
      input logic [1:0] aop, input logic [1:0] ps);
    return {pcw, io, mr, mw, irw, rw, rd, m2r, sa, sb, aop, ps};
  endfunction

  function automatic logic [16:0] ctl_for(input int st, input logic [5:0] op, input bit z);
    case (st)
      0:  return pack(1, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 2'b01, 2'b00, 2'b00);
      1:  return pack(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 2'b00, 2'b00);
      2:  return pack(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, 2'b00, 2'b00);
      3:  return pack(0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00);
      4:  return pack(0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 2'b00, 2'b00, 2'b00);
      5:  return pack(0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00);
      6:  return pack(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 2'b10, 2'b00);
      7:  return pack(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 0, 2'b00, 2'b00, 2'b00);
      8:  return pack((op == BEQ) ? z : !z, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 2'b01, 2'b01);
      9:  return pack(1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b10);
      10: return pack(1, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 2'b00, 2'b00, 2'b10);
      11: return pack(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b10, (op == SLTI) ? 2'b11 : 2'b00, 2'b00);
      12: return pack(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00);
      default: return '0;
    endcase
  endfunction

  // One instruction: opcode is only meaningful in DECODE (step 1); elsewhere it
  // is scrambled (or forced to 'late_op') to prove the latched copy is used.
  // abort_at >= 0 raises rst on that step and abandons the instruction.
  task automatic run_instr(input logic [5:0] op, input int abort_at,
                           input int zero_force, input bit use_late, input logic [5:0] late_op);
    int   s[$];
    exp_t e;
    seq_for(op, s);
    for (int i = 0; i < s.size(); i++) begin
      @(posedge clk);
      #1;
      rst    = (i == abort_at);
      opcode = (i == 1) ? op : (use_late ? late_op : 6'($urandom));
      zero   = (zero_force >= 0) ? zero_force[0] : 1'($urandom);
      e.st   = s[i][3:0];
      e.ctl  = rst ? 17'd0 : ctl_for(s[i], op, zero);
      e.tag  = $sformatf("op%b_step%0d%s", op, i, rst ? "_rst" : "");
      q.push_back(e);
      if (rst) break;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() == 0) begin
        check("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.tag, "_state"}, {28'd0, state}, {28'd0, e.st});
        check({e.tag, "_ctl"},
              {15'd0, pc_write, iord, mem_read, mem_write, ir_write, reg_write,
               reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src},
              {15'd0, e.ctl});
      end
    end
  end

  initial begin
    exp_t e;
    logic [5:0] ops [9] = '{R, J, JAL, BEQ, BNE, ADDI, SLTI, LW, SW};
    rst    = 1'b1;
    opcode = 6'b000000;
    zero   = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    e.st = 4'd0; e.ctl = '0; e.tag = "reset";
    q.push_back(e);

    // Directed cases from the functional requirements.
    run_instr(LW,        -1, -1, 0, 6'd0);
    run_instr(BEQ,       -1,  1, 0, 6'd0);
    run_instr(BEQ,       -1,  0, 0, 6'd0);
    run_instr(BNE,       -1,  1, 0, 6'd0);
    run_instr(BNE,       -1,  0, 0, 6'd0);
    run_instr(JAL,       -1, -1, 0, 6'd0);
    run_instr(6'b111111, -1, -1, 0, 6'd0);
    run_instr(SW,         2, -1, 0, 6'd0);
    run_instr(R,         -1, -1, 1, SW);
    run_instr(SW,        -1, -1, 1, LW);
    run_instr(ADDI,      -1, -1, 1, SLTI);
    run_instr(SLTI,      -1, -1, 1, ADDI);
    run_instr(LW,         3, -1, 0, 6'd0);
    run_instr(J,         -1, -1, 0, 6'd0);

    // Random instruction stream with occasional mid-instruction resets.
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      int ab;
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(op, ab, -1, 0, 6'd0);
    end

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("scoreboard_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
